// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_pattern_pkg                                            |
// | Description : Shared encodings, register map, LFSR constants and default |
// |               640x480 timing for the VGA pattern engine.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package vga_pattern_pkg;

    // Pattern generator modes held in CTRL bits 2:1
    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_NOISE   = 2'd3
    } mode_e;

    // Configuration register map
    localparam logic [1:0] c_addr_ctrl = 2'd0;
    localparam logic [1:0] c_addr_fg   = 2'd1;
    localparam logic [1:0] c_addr_bg   = 2'd2;
    localparam logic [1:0] c_addr_tile = 2'd3;

    // Galois LFSR for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Default 640x480@60 timing
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    // One LFSR step: shift right, fold the tap mask in when a one falls out
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? c_lfsr_taps : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_sync_counter                                           |
// | Description : Horizontal/vertical raster counters with registered sync,  |
// |               data-enable, position and frame-start outputs.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_sync_counter
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ena,
    output logic [9:0] o_h,            // live counters for the pattern logic
    output logic [9:0] o_v,
    output logic       o_vis,          // live counters inside the visible area
    output logic       o_frame_tick,   // this enabled cycle emits frame_start
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_frame_start
);

    localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       w_hs_on;
    logic       w_vs_on;
    logic       w_origin;

    assign w_hs_on      = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs_on      = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_origin     = (r_h == 10'd0) && (r_v == 10'd0);
    assign o_vis        = (r_h < c_h_act) && (r_v < c_v_act);
    assign o_frame_tick = i_ena && w_origin;
    assign o_h          = r_h;
    assign o_v          = r_v;

    // Raster position: h wraps each line, v steps on every h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (i_ena) begin
            if (r_h == c_h_last) begin
                r_h <= 10'd0;
                r_v <= (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // Timing outputs describe the position held before this enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_x           <= 10'd0;
            o_y           <= 10'd0;
            o_frame_start <= 1'b0;
        end else if (i_ena) begin
            o_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            o_de          <= o_vis;
            o_x           <= r_h;
            o_y           <= r_v;
            o_frame_start <= w_origin;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_pattern_engine                                         |
// | Description : VGA timing plus test-pattern generator (solid, colour bars,|
// |               checkerboard, LFSR noise) with frame-synchronous config.   |
// |               Define VGA_PATTERN_LFSR_EN to build the noise LFSR; without|
// |               it mode 3 shows the background colour.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_pattern_engine
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter int CBITS    = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [7:0]         wr_data,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [3*CBITS-1:0] rgb,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               frame_start
);

    localparam int c_cw    = 3 * CBITS;
    localparam int c_bar_w = H_ACTIVE / 8;

    logic [9:0]      w_h;
    logic [9:0]      w_v;
    logic            w_vis;
    logic            w_frame_tick;

    logic [2:0]      r_stg_ctrl;
    logic [c_cw-1:0] r_stg_fg;
    logic [c_cw-1:0] r_stg_bg;
    logic [2:0]      r_stg_tile;
    logic [2:0]      r_act_ctrl;
    logic [c_cw-1:0] r_act_fg;
    logic [c_cw-1:0] r_act_bg;
    logic [2:0]      r_act_tile;

    logic [2:0]      w_ctrl;
    logic [c_cw-1:0] w_fg;
    logic [c_cw-1:0] w_bg;
    logic [2:0]      w_tile;
    mode_e           w_mode;
    logic [2:0]      w_bar;
    logic [3:0]      w_sh;
    logic            w_chk;
    logic [c_cw-1:0] w_noise;
    logic [c_cw-1:0] w_pix;
    logic            w_unused_data;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (ena),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_vis         (w_vis),
        .o_frame_tick  (w_frame_tick),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_de          (de),
        .o_x           (x),
        .o_y           (y),
        .o_frame_start (frame_start)
    );

    // Upper write-data bits are not stored by any register
    assign w_unused_data = ^wr_data;

    // Host writes land in staging, independent of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_ctrl <= 3'd0;
            r_stg_fg   <= '0;
            r_stg_bg   <= '0;
            r_stg_tile <= 3'd0;
        end else if (wr_en) begin
            case (wr_addr)
                c_addr_ctrl: r_stg_ctrl <= wr_data[2:0];
                c_addr_fg:   r_stg_fg   <= wr_data[c_cw-1:0];
                c_addr_bg:   r_stg_bg   <= wr_data[c_cw-1:0];
                default:     r_stg_tile <= wr_data[2:0];
            endcase
        end
    end

    // Active set is reloaded only on the frame-start cycle so a frame never tears;
    // a write in that same cycle sees the old staging value (non-blocking read)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_ctrl <= 3'd0;
            r_act_fg   <= '0;
            r_act_bg   <= '0;
            r_act_tile <= 3'd0;
        end else if (w_frame_tick) begin
            r_act_ctrl <= r_stg_ctrl;
            r_act_fg   <= r_stg_fg;
            r_act_bg   <= r_stg_bg;
            r_act_tile <= r_stg_tile;
        end
    end

    // Pixel (0,0) is produced in the reload cycle, so it must already use staging
    assign w_ctrl = w_frame_tick ? r_stg_ctrl : r_act_ctrl;
    assign w_fg   = w_frame_tick ? r_stg_fg   : r_act_fg;
    assign w_bg   = w_frame_tick ? r_stg_bg   : r_act_bg;
    assign w_tile = w_frame_tick ? r_stg_tile : r_act_tile;
    assign w_mode = mode_e'(w_ctrl[2:1]);

    assign w_bar  = 3'(w_h / 10'(c_bar_w));
    assign w_sh   = {1'b0, w_tile} + 4'd3;
    assign w_chk  = 1'((w_h >> w_sh) ^ (w_v >> w_sh));

`ifdef VGA_PATTERN_LFSR_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    assign w_lfsr_nxt = lfsr_step(r_lfsr);
    assign w_noise    = w_lfsr_nxt[c_cw-1:0];

    // Noise source free-runs on every enabled cycle regardless of mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_lfsr_seed;
        end else if (ena) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_noise = w_bg;
`endif

    // Pattern selection for the live raster position
    always_comb begin
        w_pix = w_fg;
        case (w_mode)
            MODE_SOLID:   w_pix = w_fg;
            MODE_BARS:    w_pix = {{CBITS{w_bar[2]}}, {CBITS{w_bar[1]}}, {CBITS{w_bar[0]}}};
            MODE_CHECKER: w_pix = w_chk ? w_bg : w_fg;
            MODE_NOISE:   w_pix = w_noise;
        endcase
    end

    // Registered pixel, blanked outside the visible area or when output is off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (ena) begin
            rgb <= (w_vis && w_ctrl[0]) ? w_pix : '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_pattern_engine.md
VGA_PATTERN_ENGINE -- requirements
Module: vga_pattern_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch
  V_ACTIVE 480 visible lines; V_FP 10 front porch; V_SYNC 2 sync width; V_BP 33 back porch
  CBITS 2 bits per colour channel, legal range 1..2
  SYNC_POL 0 sync asserted level (0 = active-low)
REQ-002 Ports SHALL be (name direction width meaning):
  clk in 1 pixel clock
  rst_n in 1 asynchronous active-low reset
  ena in 1 advance enable; low freezes all timing and LFSR state
  wr_en in 1 config write strobe, one write per cycle
  wr_addr in 2 register select
  wr_data in 8 write data
  hsync out 1 horizontal sync; vsync out 1 vertical sync
  de out 1 data enable (visible region)
  rgb out 3*CBITS pixel {R,G,B}, each CBITS wide
  x out 10 current column; y out 10 current row
  frame_start out 1 one-cycle pulse at h=0,v=0

Function
REQ-003 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0; v SHALL increment on h wrap, counting 0..V_TOTAL-1 and wrapping.
REQ-004 Counters, LFSR and outputs SHALL advance only when ena=1; with ena=0 all outputs hold.
REQ-005 All outputs SHALL be registered; each output SHALL reflect the counter state of the previous enabled cycle (latency 1).
REQ-006 de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE; x=h, y=v.
REQ-007 hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vsync likewise on v with V params.
REQ-008 Registers: addr0 CTRL (bit0 output enable, bits2:1 mode); addr1 FG colour; addr2 BG colour; addr3 TILE (bits2:0 s, tile edge 2^(s+3) pixels); colours use bits 3*CBITS-1:0.
REQ-009 Writes SHALL land in staging registers the cycle after wr_en; active registers SHALL copy staging in the cycle frame_start is generated.
REQ-010 Write coincident with frame_start: active registers SHALL take the pre-write staging value; new value effective next frame.
REQ-011 Modes: 0 solid FG; 1 eight vertical bars of width H_ACTIVE/8, bar index i mapped R=i[2], G=i[1], B=i[0], each replicated to CBITS; 2 checkerboard, FG where (x>>(s+3)) XOR (y>>(s+3)) bit0 = 0, else BG; 3 LFSR noise.
REQ-012 rgb SHALL be 0 when de=0 or active CTRL.bit0=0.
REQ-013 LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing every enabled cycle; noise rgb = LFSR[3*CBITS-1:0].

Reset
REQ-014 rst_n low SHALL immediately clear h, v, x, y, de, rgb, frame_start, all staging and active registers; hsync/vsync SHALL go to ~SYNC_POL; LFSR SHALL load 16'hACE1.
REQ-015 Reset mid-frame SHALL restart timing at h=0,v=0; first frame_start SHALL appear one enabled cycle after release.

Configuration
REQ-016 Macro VGA_PATTERN_LFSR_EN defined: mode 3 SHALL produce LFSR noise; undefined: no LFSR is built and mode 3 SHALL output BG colour.

Structure
REQ-017 Package vga_pattern_pkg SHALL hold mode encodings, register address constants, LFSR seed/taps and default 640x480 timing constants.
REQ-018 Sub-module vga_sync_counter SHALL contain h/v counters and de/hsync/vsync/frame_start generation; pattern logic and register file stay in the top.

Verification
REQ-019 Bench SHALL cover:
  Reset release, ena=1, defaults -> frame_start pulse after 1 cycle, then every 420000 cycles; hsync low for h 656..751 (96 cycles), vsync low on lines 490..491.
  Write CTRL=0x01, FG=0x30 mid-frame -> rgb stays 0 until next frame_start, then 6'b110000 for all de cycles.
  CTRL=0x03 (bars) -> x=0..79 rgb 0, x=80..159 6'b000011, x=560..639 6'b111111.
  CTRL=0x05, FG=0x3F, BG=0x00, TILE=0 -> rgb toggles every 8 pixels, phase inverted on line 8.
  ena held low 100 cycles mid-line -> all outputs unchanged; resume continues from same h.
  Macro undefined, CTRL=0x07, BG=0x0C -> rgb 6'b001100 in visible region; defined -> first noise pixel = 16'hACE1 stepped once, low 6 bits.
